// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and constants for the pipeline sequencing controller
package pipe_ctrl_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MDU_BUSY = 1'b1
  } ctrl_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_cmp.sv
// rtl/hazard_cmp.sv - source/destination match of the ID sources against one later stage
import pipe_ctrl_pkg::*;

module hazard_cmp (
  input  logic [4:0] rs_addr,
  input  logic       rs_used,
  input  logic [4:0] rt_addr,
  input  logic       rt_used,
  input  logic [4:0] rd_waddr,
  input  logic       rd_wena,
  output logic       match
);

  logic dest_live;
  logic rs_hit;
  logic rt_hit;

  // A stage only produces a hazard when it really writes a non-zero register.
  always_comb begin
    dest_live = rd_wena && (rd_waddr != REG_ZERO);
    rs_hit    = dest_live && rs_used && (rs_addr == rd_waddr);
    rt_hit    = dest_live && rt_used && (rt_addr == rd_waddr);
    match     = rs_hit || rt_hit;
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - load-use/branch hazard detection and MDU front-end freeze
import pipe_ctrl_pkg::*;

module pipe_hazard_ctrl #(
  parameter int MDU_LAT = 32
) (
  input  logic        in_clk,
  input  logic        in_rst,
  input  logic [4:0]  in_id_rs_addr,
  input  logic [4:0]  in_id_rt_addr,
  input  logic        in_id_rs_used,
  input  logic        in_id_rt_used,
  input  logic        in_id_is_branch,
  input  logic        in_id_branch_taken,
  input  logic        in_id_is_mdu,
  input  logic [4:0]  in_ex_rd_waddr,
  input  logic        in_ex_rd_wena,
  input  logic        in_ex_is_load,
  input  logic [4:0]  in_mem_rd_waddr,
  input  logic        in_mem_rd_wena,
  input  logic        in_mem_is_load,
  output logic        out_pc_hold,
  output logic        out_if_id_hold,
  output logic        out_if_id_flush,
  output logic        out_id_ex_bubble,
  output logic        out_mdu_start,
  output logic        out_mdu_busy,
  output logic [31:0] out_stall_cnt
);

  // The issue cycle counts toward occupancy, so the busy window is one shorter.
  localparam logic [5:0] CNT_LOAD = 6'(MDU_LAT - 1);

  ctrl_state_t state;
  ctrl_state_t state_nxt;
  logic [5:0]  cnt;
  logic [5:0]  cnt_nxt;

  logic ex_match;
  logic mem_match;
  logic lu_haz;
  logic br_haz;
  logic stall;

  hazard_cmp u_cmp_ex (
    .rs_addr  (in_id_rs_addr),
    .rs_used  (in_id_rs_used),
    .rt_addr  (in_id_rt_addr),
    .rt_used  (in_id_rt_used),
    .rd_waddr (in_ex_rd_waddr),
    .rd_wena  (in_ex_rd_wena),
    .match    (ex_match)
  );

  hazard_cmp u_cmp_mem (
    .rs_addr  (in_id_rs_addr),
    .rs_used  (in_id_rs_used),
    .rt_addr  (in_id_rt_addr),
    .rt_used  (in_id_rt_used),
    .rd_waddr (in_mem_rd_waddr),
    .rd_wena  (in_mem_rd_wena),
    .match    (mem_match)
  );

  // Hazards only matter while the front end is running; MDU occupancy overrides them.
  always_comb begin
    lu_haz = (state == RUN) && ex_match && in_ex_is_load;
    br_haz = (state == RUN) && in_id_is_branch &&
             (ex_match || (mem_match && in_mem_is_load));
    stall  = lu_haz || br_haz;
  end

  // State and MDU occupancy counter.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      state <= RUN;
      cnt   <= 6'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state and pipeline controls; everything is held low while reset is asserted.
  always_comb begin
    state_nxt        = state;
    cnt_nxt          = cnt;
    out_pc_hold      = 1'b0;
    out_if_id_hold   = 1'b0;
    out_if_id_flush  = 1'b0;
    out_id_ex_bubble = 1'b0;
    out_mdu_start    = 1'b0;
    out_mdu_busy     = 1'b0;
    if (!in_rst) begin
      case (state)
        MDU_BUSY: begin
          out_pc_hold      = 1'b1;
          out_if_id_hold   = 1'b1;
          out_id_ex_bubble = 1'b1;
          out_mdu_busy     = 1'b1;
          cnt_nxt          = cnt - 6'd1;
          if (cnt == 6'd1) begin
            state_nxt = RUN;
          end
        end
        default: begin
          if (stall) begin
            out_pc_hold      = 1'b1;
            out_if_id_hold   = 1'b1;
            out_id_ex_bubble = 1'b1;
          end else begin
            out_if_id_flush = in_id_branch_taken;
            if (in_id_is_mdu) begin
              out_mdu_start = 1'b1;
              cnt_nxt       = CNT_LOAD;
              state_nxt     = MDU_BUSY;
            end
          end
        end
      endcase
    end
  end

  // Saturating count of front-end hold cycles.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      out_stall_cnt <= 32'd0;
    end else if (out_pc_hold && (out_stall_cnt != 32'hFFFF_FFFF)) begin
      out_stall_cnt <= out_stall_cnt + 32'd1;
    end
  end

endmodule
